mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF) and the data-memory requester (MEM stage).
- Serializes the accesses and returns read data or write acks. Drives per-requester stall outputs that the pipeline uses to freeze the PC/IF-ID registers or the EX-MEM stage.
- Data accesses have priority over fetches. A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// Data wins arbitration; a starvation counter forces fetch progress.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_dm,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_LD  = 4'(MEM_LAT - 1);
    localparam logic [3:0] STV_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nx;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       any_req;
    logic       if_win;

    assign any_req   = if_req | dm_req;
    assign if_win    = if_req & (~dm_req | (starve_cnt == STV_LIM));
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mem_en   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latch the winner's request and track fetch starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            grant_dm   <= 1'b0;
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (any_req) begin
                grant_dm  <= ~if_win;
                mem_addr  <= if_win ? if_addr : dm_addr;
                mem_we    <= ~if_win & dm_we;
                mem_wdata <= if_win ? '0 : dm_wdata;
            end
            if (~if_req || if_win) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt < STV_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Latency countdown, read-data capture and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt  <= 4'd0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (state == ISSUE) begin
                lat_cnt <= LAT_LD;
            end else if (state == WAIT) begin
                if (lat_cnt == 4'd0) begin
                    if (grant_dm) begin
                        dm_valid <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end else begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
// Completions are popped from an expectation queue as valid pulses appear.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    typedef struct {
        bit          dm;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        grant_dm;
    logic        busy;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    logic [31:0] mem [logic [31:0]];
    int          m_cnt = 0;
    logic [31:0] m_data = '0;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .grant_dm (grant_dm),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: data is only valid exactly LAT cycles after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            m_data <= mem_rd(mem_addr);
            m_cnt  <= LAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign mem_rdata = (m_cnt == 1) ? m_data : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_dm_valid"}, dm_valid, 0);
        chk({tag, "_grant_dm"}, grant_dm, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Follow one request from cycle 0, then drop it after its valid.
    task automatic track(input bit dm, input int t_iss, input int t_val,
                         input logic [31:0] addr, input bit we,
                         input logic [31:0] wdata, input string tag);
        int  c    = 0;
        bit  seen = 0;
        bit  iss  = 0;
        bit  v;
        while (!seen && c <= t_val + 8) begin
            @(negedge clk);
            if (mem_en && grant_dm == dm && !iss) begin
                iss = 1;
                chk({tag, "_iss"}, c, t_iss);
                chk({tag, "_addr"}, mem_addr, addr);
                chk({tag, "_we"}, mem_we, we);
                if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
            end
            v = dm ? dm_valid : if_valid;
            chk({tag, "_stall"}, dm ? stall_mem : stall_if, !v);
            if (v) begin
                seen = 1;
                chk({tag, "_val"}, c, t_val);
            end
            c++;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        if (dm) dm_req = 0;
        else if_req = 0;
    endtask

    // Scoreboard: every completion pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && (if_valid || dm_valid)) begin
            chk("one_valid", if_valid & dm_valid, 0);
            if (sb.size() == 0) begin
                chk("unexp_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_who", dm_valid, e.dm);
                chk("rdata", dm_valid ? dm_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nval;
        rst_n    = 0;
        if_req   = 0;
        if_addr  = 0;
        dm_req   = 0;
        dm_we    = 0;
        dm_addr  = 0;
        dm_wdata = 0;
        mem[32'h100] = 32'h0050_0093;
        mem[32'h200] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        chk("rst_stall", stall_if | stall_mem, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // IF read
        @(posedge clk);
        #1;
        if_req  = 1;
        if_addr = 32'h100;
        sb.push_back('{0, 32'h0050_0093});
        track(0, 1, LAT + 2, 32'h100, 0, 0, "ifrd");

        // Simultaneous requests: data first, then fetch
        @(posedge clk);
        #1;
        if_req  = 1;
        dm_req  = 1;
        dm_we   = 0;
        dm_addr = 32'h200;
        sb.push_back('{1, 32'hDEAD_BEEF});
        sb.push_back('{0, 32'h0050_0093});
        fork
            track(1, 1, LAT + 2, 32'h200, 0, 0, "dmrd");
            track(0, LAT + 4, 2 * LAT + 5, 32'h100, 0, 0, "ifwt");
        join

        // Store leaves both rdata registers alone
        @(posedge clk);
        #1;
        dm_req   = 1;
        dm_we    = 1;
        dm_addr  = 32'h40;
        dm_wdata = 32'h1234_5678;
        sb.push_back('{1, 32'hDEAD_BEEF});
        track(1, 1, LAT + 2, 32'h40, 1, 32'h1234_5678, "st");
        chk("st_if_rdata", if_rdata, 32'h0050_0093);
        dm_we = 0;

        // Load back the stored word
        @(posedge clk);
        #1;
        dm_req  = 1;
        dm_addr = 32'h40;
        sb.push_back('{1, 32'h1234_5678});
        track(1, 1, LAT + 2, 32'h40, 0, 0, "ldbk");

        // Both held: data wins SMAX times, then fetch is forced
        @(posedge clk);
        #1;
        if_req  = 1;
        if_addr = 32'h100;
        dm_req  = 1;
        dm_addr = 32'h200;
        for (int i = 0; i < 2 * (SMAX + 1); i++) begin
            if ((i % (SMAX + 1)) == SMAX)
                sb.push_back('{0, 32'h0050_0093});
            else
                sb.push_back('{1, 32'hDEAD_BEEF});
        end
        nval = 0;
        for (int c = 0; c < 4 * (SMAX + 1) * (LAT + 3); c++) begin
            @(negedge clk);
            if (if_valid || dm_valid) nval++;
            if (nval == 2 * (SMAX + 1)) break;
        end
        @(posedge clk);
        #1;
        if_req = 0;
        dm_req = 0;
        chk("starve_nval", nval, 2 * (SMAX + 1));
        repeat (LAT + 4) @(negedge clk);
        chk("starve_sb", sb.size(), 0);

        // Reset during WAIT aborts the access silently
        @(posedge clk);
        #1;
        if_req  = 1;
        if_addr = 32'h104;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #1 rst_n = 0;
        #1;
        check_zero("arst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        sb.push_back('{0, mem_rd(32'h104)});
        track(0, 1, LAT + 2, 32'h104, 0, 0, "post");

        repeat (LAT + 4) @(negedge clk);
        chk("final_sb", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
